router_tx_buf: RTL and testbench

//  Transmit-side buffer between a PE output and one router input port (D/D_VALID/D_BP).

---
 rtl/router_tx_buf_if.sv | 21 ++
 rtl/router_tx_buf.sv | 113 +++++++++++
 tb/tb_router_tx_buf.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/router_tx_buf_if.sv
// rtl/router_tx_buf_if.sv - PE-side and router-side stream signals of the tx buffer
interface router_tx_buf_if;
   logic [63:0] in_d;
   logic        in_valid;
   logic        in_last;
   logic        in_bp;
   logic [63:0] q;
   logic        q_valid;
   logic        q_bp;
   logic        q_sof;

   modport slave (
      input  in_d, in_valid, in_last, q_bp,
      output in_bp, q, q_valid, q_sof
   );

   modport master (
      output in_d, in_valid, in_last, q_bp,
      input  in_bp, q, q_valid, q_sof
   );
endinterface

// File: rtl/router_tx_buf.sv
// rtl/router_tx_buf.sv - store-and-forward PE-to-router tx buffer with SOF marking
module router_tx_buf #(
   parameter int DEPTH = 16,
   parameter int AFULL = 2
) (
   input logic            clk,
   input logic            rst_n,
   router_tx_buf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_W = (AW+1)'(AFULL);

   typedef enum logic {IDLE, SEND} state_t;

   state_t      state_q, state_d;
   logic [64:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, count, count_next, free_next;
   logic [AW:0] pkt_cnt, pkt_cnt_next;
   logic [64:0] rd_word;
   logic        full, empty, wr_en, rd_en, rd_last, wr_last;
   logic        bp_q, sof_pend, sof_pend_d, ovf_err;
   logic [63:0] q_r;
   logic        q_valid_r, q_sof_r, in_bp_r;

   assign count      = wr_ptr - rd_ptr;
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty      = (wr_ptr == rd_ptr);
   assign wr_en      = bus.in_valid && !full;
   assign wr_last    = wr_en && bus.in_last;
   assign rd_word    = mem[rd_ptr[AW-1:0]];
   assign rd_last    = rd_word[64];
   assign count_next = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
   assign free_next  = DEPTH_W - count_next;

   always_comb begin
      pkt_cnt_next = pkt_cnt;
      case ({wr_last, rd_en && rd_last})
         2'b10:   pkt_cnt_next = pkt_cnt + PTR_ONE;
         2'b01:   pkt_cnt_next = pkt_cnt - PTR_ONE;
         default: pkt_cnt_next = pkt_cnt;
      endcase
   end

   // A full FIFO with no complete packet can only drain by cut-through.
   always_comb begin
      state_d    = state_q;
      sof_pend_d = sof_pend;
      rd_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pkt_cnt != '0 || full) begin
               state_d    = SEND;
               sof_pend_d = 1'b1;
            end
         end
         SEND: begin
            if (!bp_q && !empty) begin
               rd_en      = 1'b1;
               sof_pend_d = 1'b0;
               if (rd_last) begin
                  sof_pend_d = 1'b1;
                  if (pkt_cnt == PTR_ONE && !wr_last) state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {bus.in_last, bus.in_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pkt_cnt   <= '0;
         bp_q      <= 1'b0;
         sof_pend  <= 1'b0;
         ovf_err   <= 1'b0;
         in_bp_r   <= 1'b0;
         q_r       <= '0;
         q_valid_r <= 1'b0;
         q_sof_r   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sof_pend <= sof_pend_d;
         pkt_cnt  <= pkt_cnt_next;
         bp_q     <= bus.q_bp;
         ovf_err  <= ovf_err | (bus.in_valid & full);
         in_bp_r  <= (free_next <= AFULL_W);
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            q_r       <= rd_word[63:0];
            q_valid_r <= 1'b1;
            q_sof_r   <= sof_pend;
         end else begin
            q_valid_r <= 1'b0;
            q_sof_r   <= 1'b0;
         end
      end
   end

   assign bus.q       = q_r;
   assign bus.q_valid = q_valid_r;
   assign bus.q_sof   = q_sof_r;
   assign bus.in_bp   = in_bp_r;
endmodule

// File: tb/tb_router_tx_buf.sv
// tb/tb_router_tx_buf.sv - directed scoreboard bench for router_tx_buf
module tb_router_tx_buf;
   localparam int DEPTH = 16;
   localparam int AFULL = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   int          ref_cyc = 0;
   int          k = 0;
   logic [64:0] exp_q[$];
   int          beat_cyc[$];

   router_tx_buf_if bus();

   router_tx_buf #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      logic [64:0] e;
      if (bus.q_valid === 1'b1) begin
         beat_cyc.push_back(cyc);
         check("sb_word_expected", 65'(exp_q.size() != 0), 65'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_sof_data", {bus.q_sof, bus.q}, e);
         end
      end else begin
         check("sof_without_valid", 65'(bus.q_sof), 65'd0);
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send_word(input logic [63:0] d, input logic last, input logic first);
      bus.in_d     = d;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      exp_q.push_back({first, d});
      last_cyc = cyc;
      step();
   endtask

   task automatic send_pkt(input logic [63:0] base, input int n);
      for (int i = 0; i < n; i++)
         send_word(base + 64'(i + 1), i == n - 1, i == 0);
   endtask

   task automatic drain(input int n);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      bus.in_d     = '0;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.q_bp     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", {1'b0, bus.q}, 65'd0);
      check("rst_q_valid", 65'(bus.q_valid), 65'd0);
      check("rst_q_sof", 65'(bus.q_sof), 65'd0);
      check("rst_in_bp", 65'(bus.in_bp), 65'd0);
      check("rst_pkt_cnt", 65'(dut.pkt_cnt), 65'd0);
      rst_n = 1'b1;
      drain(2);

      // single 4-word packet
      beat_cyc.delete();
      send_pkt(64'hA5A5_0000_0000_0000, 4);
      drain(10);
      check("t1_beats", 65'(beat_cyc.size()), 65'd4);
      if (beat_cyc.size() == 4) begin
         check("t1_latency", 65'(beat_cyc[0] - last_cyc), 65'd3);
         check("t1_contiguous", 65'(beat_cyc[3] - beat_cyc[0]), 65'd3);
      end

      // PE stall mid-packet must not fragment the output
      beat_cyc.delete();
      send_word(64'hB000_0000_0000_0001, 1'b0, 1'b1);
      send_word(64'hB000_0000_0000_0002, 1'b0, 1'b0);
      drain(5);
      check("t2_hold_until_last", 65'(beat_cyc.size()), 65'd0);
      send_word(64'hB000_0000_0000_0003, 1'b0, 1'b0);
      send_word(64'hB000_0000_0000_0004, 1'b1, 1'b0);
      drain(10);
      check("t2_beats", 65'(beat_cyc.size()), 65'd4);
      if (beat_cyc.size() == 4) begin
         check("t2_latency", 65'(beat_cyc[0] - last_cyc), 65'd3);
         check("t2_contiguous", 65'(beat_cyc[3] - beat_cyc[0]), 65'd3);
      end

      // back-to-back packets
      beat_cyc.delete();
      send_pkt(64'hC100_0000_0000_0000, 3);
      send_pkt(64'hC200_0000_0000_0000, 3);
      drain(12);
      check("t3_beats", 65'(beat_cyc.size()), 65'd6);
      if (beat_cyc.size() == 6)
         check("t3_contiguous", 65'(beat_cyc[5] - beat_cyc[0]), 65'd5);

      // router backpressure mid-packet
      beat_cyc.delete();
      send_pkt(64'hD000_0000_0000_0000, 8);
      bus.in_valid = 1'b0;
      while (cyc < last_cyc + 4) step();
      bus.q_bp = 1'b1;
      ref_cyc = cyc;
      repeat (4) step();
      bus.q_bp = 1'b0;
      drain(15);
      check("t4_beats", 65'(beat_cyc.size()), 65'd8);
      if (beat_cyc.size() == 8) begin
         check("t4_last_before_stop", 65'(beat_cyc[2] - ref_cyc), 65'd1);
         check("t4_resume", 65'(beat_cyc[3] - ref_cyc), 65'd6);
      end

      // oversize packet: fill under backpressure, then cut-through
      bus.q_bp = 1'b1;
      drain(2);
      beat_cyc.delete();
      for (int i = 0; i < 16; i++) begin
         if (i == 13) check("t5_in_bp_free3", 65'(bus.in_bp), 65'd0);
         if (i == 14) check("t5_in_bp_free2", 65'(bus.in_bp), 65'd1);
         send_word(64'hE000_0000_0000_0000 + 64'(i), 1'b0, i == 0);
      end
      bus.in_valid = 1'b0;
      check("t5_full", 65'(dut.full), 65'd1);
      check("t5_in_bp_full", 65'(bus.in_bp), 65'd1);
      check("t5_no_output_under_bp", 65'(beat_cyc.size()), 65'd0);
      bus.q_bp = 1'b0;
      for (int i = 16; i < 20; i++) begin
         bus.in_valid = 1'b0;
         k = 0;
         while (bus.in_bp === 1'b1 && k < 50) begin
            step();
            k++;
         end
         check("t5_in_bp_release", 65'(bus.in_bp), 65'd0);
         send_word(64'hE000_0000_0000_0000 + 64'(i), i == 19, 1'b0);
      end
      drain(40);
      check("t5_beats", 65'(beat_cyc.size()), 65'd20);
      check("t5_sb_empty", 65'(exp_q.size()), 65'd0);
      check("t5_no_ovf", 65'(dut.ovf_err), 65'd0);

      // asynchronous reset mid-packet
      beat_cyc.delete();
      send_pkt(64'hF100_0000_0000_0000, 4);
      send_word(64'hF200_0000_0000_0001, 1'b0, 1'b1);
      send_word(64'hF200_0000_0000_0002, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      check("t6_pre_reset_valid", 65'(bus.q_valid), 65'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_q", {1'b0, bus.q}, 65'd0);
      check("t6_rst_q_valid", 65'(bus.q_valid), 65'd0);
      check("t6_rst_q_sof", 65'(bus.q_sof), 65'd0);
      check("t6_rst_pkt_cnt", 65'(dut.pkt_cnt), 65'd0);
      exp_q.delete();
      beat_cyc.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
      drain(2);
      send_pkt(64'h1234_0000_0000_0000, 2);
      drain(10);
      check("t6_fresh_beats", 65'(beat_cyc.size()), 65'd2);
      check("t6_sb_empty", 65'(exp_q.size()), 65'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
